// File: rtl/tdiv_result_buffer_pkg.sv
// rtl/tdiv_result_buffer_pkg.sv - shared flag indices and word-width helpers for tdiv and its result buffer
package tdiv_result_buffer_pkg;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_INF  = 1;
  localparam int FLAG_NAN  = 2;
  localparam int FLAG_W    = 3;

  // Sign + exponent + fraction; the divider sizes its quotient with the same function.
  function automatic int word_width(input int exp_w, input int fra_w);
    return exp_w + fra_w + 1;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

endpackage

// File: rtl/tdiv_result_buffer_sync_fifo_fwft.sv
// rtl/tdiv_result_buffer_sync_fifo_fwft.sv - first-word fall-through FIFO with occupancy count
module sync_fifo_fwft #(
  parameter int W     = 19,
  parameter int DEPTH = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     wr_valid,
  input  logic [W-1:0]             wr_data,
  output logic                     wr_accept,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          rd_fire;

  assign full      = (fill == FULL_CNT);
  assign empty     = (fill == '0);
  assign rd_valid  = !empty;
  assign rd_fire   = rd_valid && rd_ready;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign wr_accept = wr_valid && (!full || rd_fire);
  assign rd_data   = mem[rd_ptr];

  always_ff @(posedge aclk) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire)   rd_ptr <= rd_ptr + AW'(1);
      if (wr_accept && !rd_fire)      fill <= fill + (AW+1)'(1);
      else if (rd_fire && !wr_accept) fill <= fill - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/tdiv_result_buffer.sv
// rtl/tdiv_result_buffer.sv - elastic AXI-Stream output stage for tdiv with issue credits and flag statistics
module tdiv_result_buffer
  import tdiv_result_buffer_pkg::*;
#(
  parameter int EXP   = 5,
  parameter int FRA   = 10,
  parameter int DEPTH = 8
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              s_issue,
  output logic                              s_credit_ok,
  input  logic [word_width(EXP, FRA)-1:0]   s_axis_tdata,
  input  logic [2:0]                        s_axis_tflag,
  input  logic                              s_axis_tvalid,
  output logic [word_width(EXP, FRA)-1:0]   m_axis_tdata,
  output logic [2:0]                        m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [$clog2(DEPTH):0]            fill,
  output logic                              overflow,
  output logic                              issue_err,
  input  logic                              clr_stats,
  output logic [15:0]                       cnt_zero,
  output logic [15:0]                       cnt_inf,
  output logic [15:0]                       cnt_nan
);

  localparam int W  = word_width(EXP, FRA);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CRED_MAX = (AW+1)'(DEPTH);

  logic             pop;
  logic             push_ok;
  logic [W+2:0]     rd_word;
  logic [AW:0]      credits;

  sync_fifo_fwft #(.W(W + FLAG_W), .DEPTH(DEPTH)) u_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .wr_valid  (s_axis_tvalid),
    .wr_data   ({s_axis_tflag, s_axis_tdata}),
    .wr_accept (push_ok),
    .rd_valid  (m_axis_tvalid),
    .rd_ready  (m_axis_tready),
    .rd_data   (rd_word),
    .fill      (fill)
  );

  assign m_axis_tdata = rd_word[W-1:0];
  assign m_axis_tuser = rd_word[W+2:W];
  assign pop          = m_axis_tvalid && m_axis_tready;
  assign s_credit_ok  = (credits != '0);

  // Credits track DEPTH minus (in flight + stored); an issue with no credit is an upstream bug.
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      credits <= CRED_MAX;
    end else if (s_issue && !pop) begin
      if (credits != '0) credits <= credits - (AW+1)'(1);
    end else if (pop && !s_issue) begin
      if (credits != CRED_MAX) credits <= credits + (AW+1)'(1);
    end else if (s_issue && pop && credits == '0) begin
      credits <= (AW+1)'(1);
    end
  end

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      overflow  <= 1'b0;
      issue_err <= 1'b0;
      cnt_zero  <= '0;
      cnt_inf   <= '0;
      cnt_nan   <= '0;
    end else if (clr_stats) begin
      overflow  <= 1'b0;
      issue_err <= 1'b0;
      cnt_zero  <= '0;
      cnt_inf   <= '0;
      cnt_nan   <= '0;
    end else begin
      if (s_axis_tvalid && !push_ok) overflow <= 1'b1;
      if (s_issue && credits == '0)  issue_err <= 1'b1;
      if (push_ok) begin
        if (s_axis_tflag[FLAG_ZERO]) cnt_zero <= sat_inc(cnt_zero);
        if (s_axis_tflag[FLAG_INF])  cnt_inf  <= sat_inc(cnt_inf);
        if (s_axis_tflag[FLAG_NAN])  cnt_nan  <= sat_inc(cnt_nan);
      end
    end
  end

endmodule

// File: tb/tb_tdiv_result_buffer.sv
// tb/tb_tdiv_result_buffer.sv - directed self-checking bench for tdiv_result_buffer
module tb_tdiv_result_buffer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        s_issue = 1'b0;
  logic        s_credit_ok;
  logic [15:0] s_axis_tdata = '0;
  logic [2:0]  s_axis_tflag = '0;
  logic        s_axis_tvalid = 1'b0;
  logic [15:0] m_axis_tdata;
  logic [2:0]  m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [3:0]  fill;
  logic        overflow;
  logic        issue_err;
  logic        clr_stats = 1'b0;
  logic [15:0] cnt_zero;
  logic [15:0] cnt_inf;
  logic [15:0] cnt_nan;

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  tdiv_result_buffer #(.EXP(5), .FRA(10), .DEPTH(8)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_issue       (s_issue),
    .s_credit_ok   (s_credit_ok),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tflag  (s_axis_tflag),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .fill          (fill),
    .overflow      (overflow),
    .issue_err     (issue_err),
    .clr_stats     (clr_stats),
    .cnt_zero      (cnt_zero),
    .cnt_inf       (cnt_inf),
    .cnt_nan       (cnt_nan)
  );

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    s_issue       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tflag  = '0;
    clr_stats     = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    m_axis_tready = 1'b0;
    aresetn = 1'b1;
    step();
    step();
    aresetn = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    aresetn = 1'b1;
    step();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
    checks++; if (fill !== 4'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill); end
    checks++; if (s_credit_ok !== 1'b1) begin errors++; $display("FAIL reset_credit_ok: got %b expected 1", s_credit_ok); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (issue_err !== 1'b0) begin errors++; $display("FAIL reset_issue_err: got %b expected 0", issue_err); end
    checks++; if ({cnt_zero, cnt_inf, cnt_nan} !== 48'd0) begin errors++; $display("FAIL reset_counters: got %h expected 0", {cnt_zero, cnt_inf, cnt_nan}); end
    aresetn = 1'b0;
    step();
  endtask

  task automatic test_basic_order();
    m_axis_tready = 1'b1;
    s_issue = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 16'h3C00; s_axis_tflag = 3'b000;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL order_no_bypass: got tvalid %b expected 0", m_axis_tvalid); end
    step();
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h3C00) begin errors++; $display("FAIL order_w0: got %b/%h expected 1/3c00", m_axis_tvalid, m_axis_tdata); end
    s_axis_tdata = 16'h4000;
    step();
    checks++; if (m_axis_tdata !== 16'h4000) begin errors++; $display("FAIL order_w1: got %h expected 4000", m_axis_tdata); end
    s_axis_tdata = 16'h7C00; s_axis_tflag = 3'b010;
    step();
    checks++; if (m_axis_tdata !== 16'h7C00 || m_axis_tuser !== 3'b010) begin errors++; $display("FAIL order_w2: got %h/%b expected 7c00/010", m_axis_tdata, m_axis_tuser); end
    idle();
    step();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL order_empty: got tvalid %b expected 0", m_axis_tvalid); end
    checks++; if (cnt_inf !== 16'd1) begin errors++; $display("FAIL order_cnt_inf: got %0d expected 1", cnt_inf); end
    checks++; if (s_credit_ok !== 1'b1) begin errors++; $display("FAIL order_credit_ok: got %b expected 1", s_credit_ok); end
  endtask

  task automatic test_fill_drain();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_issue = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 16'(16'h1000 + i);
      step();
    end
    idle();
    checks++; if (fill !== 4'd8) begin errors++; $display("FAIL fill_count: got %0d expected 8", fill); end
    checks++; if (s_credit_ok !== 1'b0) begin errors++; $display("FAIL fill_credit_ok: got %b expected 0", s_credit_ok); end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'(16'h1000 + i)) begin errors++; $display("FAIL drain_word%0d: got %b/%h expected 1/%h", i, m_axis_tvalid, m_axis_tdata, 16'(16'h1000 + i)); end
      step();
    end
    checks++; if (m_axis_tvalid !== 1'b0 || fill !== 4'd0) begin errors++; $display("FAIL drain_empty: got %b/%0d expected 0/0", m_axis_tvalid, fill); end
    m_axis_tready = 1'b0;
    s_issue = 1'b1;
    repeat (7) step();
    checks++; if (s_credit_ok !== 1'b1) begin errors++; $display("FAIL credits_after7: got %b expected 1", s_credit_ok); end
    step();
    checks++; if (s_credit_ok !== 1'b0) begin errors++; $display("FAIL credits_after8: got %b expected 0", s_credit_ok); end
    idle();
  endtask

  task automatic test_credit_err();
    s_issue = 1'b1;
    step();
    checks++; if (issue_err !== 1'b1 || s_credit_ok !== 1'b0) begin errors++; $display("FAIL cred_err_set: got %b/%b expected 1/0", issue_err, s_credit_ok); end
    s_issue = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = 16'h2222;
    step();
    s_axis_tvalid = 1'b0; s_issue = 1'b1; m_axis_tready = 1'b1;
    step();
    checks++; if (s_credit_ok !== 1'b1 || fill !== 4'd0) begin errors++; $display("FAIL cred_zero_issue_pop: got %b/%0d expected 1/0", s_credit_ok, fill); end
    s_issue = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = 16'h3333; m_axis_tready = 1'b0;
    step();
    s_axis_tvalid = 1'b0; s_issue = 1'b1; m_axis_tready = 1'b1;
    step();
    checks++; if (s_credit_ok !== 1'b1 || fill !== 4'd0) begin errors++; $display("FAIL cred_issue_pop_hold: got %b/%0d expected 1/0", s_credit_ok, fill); end
    m_axis_tready = 1'b0;
    step();
    checks++; if (s_credit_ok !== 1'b0) begin errors++; $display("FAIL cred_last_issue: got %b expected 0", s_credit_ok); end
    idle();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    checks++; if (issue_err !== 1'b0) begin errors++; $display("FAIL cred_err_clear: got %b expected 0", issue_err); end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_q [9];
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 16'(16'h5000 + i); s_axis_tflag = 3'b000;
      step();
    end
    s_axis_tdata = 16'h5999; s_axis_tflag = 3'b001;
    step();
    checks++; if (overflow !== 1'b1 || fill !== 4'd8) begin errors++; $display("FAIL ovf_drop: got %b/%0d expected 1/8", overflow, fill); end
    s_axis_tdata = 16'h5AAA; s_axis_tflag = 3'b000; m_axis_tready = 1'b1;
    step();
    checks++; if (fill !== 4'd8) begin errors++; $display("FAIL ovf_full_push_pop: got %0d expected 8", fill); end
    idle();
    for (int i = 0; i < 7; i++) exp_q[i] = 16'(16'h5001 + i);
    exp_q[7] = 16'h5AAA;
    for (int i = 0; i < 8; i++) begin
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_q[i]) begin errors++; $display("FAIL ovf_drain%0d: got %b/%h expected 1/%h", i, m_axis_tvalid, m_axis_tdata, exp_q[i]); end
      step();
    end
    checks++; if (m_axis_tvalid !== 1'b0 || cnt_zero !== 16'd0) begin errors++; $display("FAIL ovf_tail: got %b/%0d expected 0/0", m_axis_tvalid, cnt_zero); end
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_saturation();
    apply_reset();
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1; s_axis_tdata = 16'h7E00; s_axis_tflag = 3'b100;
    repeat (65534) step();
    checks++; if (cnt_nan !== 16'hFFFE) begin errors++; $display("FAIL sat_preload: got %h expected fffe", cnt_nan); end
    repeat (3) step();
    checks++; if (cnt_nan !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", cnt_nan); end
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    checks++; if (cnt_nan !== 16'd0) begin errors++; $display("FAIL sat_clear_priority: got %h expected 0", cnt_nan); end
    s_axis_tflag = 3'b011;
    step();
    checks++; if (cnt_zero !== 16'd1 || cnt_inf !== 16'd1 || cnt_nan !== 16'd0) begin errors++; $display("FAIL sat_multi_flag: got %0d/%0d/%0d expected 1/1/0", cnt_zero, cnt_inf, cnt_nan); end
    idle();
    step();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 16'(16'h6000 + i);
      step();
    end
    idle();
    checks++; if (fill !== 4'd5 || m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL mid_preload: got %0d/%b expected 5/1", fill, m_axis_tvalid); end
    #2;
    aresetn = 1'b1;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0 || fill !== 4'd0 || s_credit_ok !== 1'b1) begin errors++; $display("FAIL mid_async_reset: got %b/%0d/%b expected 0/0/1", m_axis_tvalid, fill, s_credit_ok); end
    step();
    aresetn = 1'b0;
    s_issue = 1'b1;
    repeat (7) step();
    checks++; if (s_credit_ok !== 1'b1) begin errors++; $display("FAIL mid_credits7: got %b expected 1", s_credit_ok); end
    step();
    checks++; if (s_credit_ok !== 1'b0) begin errors++; $display("FAIL mid_credits8: got %b expected 0", s_credit_ok); end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_fill_drain();
    test_credit_err();
    test_overflow();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdiv_result_buffer.md
# tdiv_result_buffer

Elastic output stage placed directly downstream of the half-precision divider `tdiv`. The divider has no result backpressure, so this block does three things:
- Captures every quotient word and its 3-bit special-value flag into a FIFO.
- Re-emits them on an AXI-Stream master port that honours `tready`.
- Runs a credit counter so the operand issuer launches a division only when buffer space is guaranteed.

It also keeps saturating statistics of zero, Inf and NaN results for debug readout.

## Interface
Parameters:
- `EXP`, default 5: exponent width.
- `FRA`, default 10: fraction width. Data word width is W = EXP+FRA+1.
- `DEPTH`, default 8: FIFO entries. Must be a power of two and at least 2. AW = log2(DEPTH).

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: reset. Reset aresetn, asynchronous, active-high; clock aclk.
- `s_issue` in 1: upstream launched one division this cycle.
- `s_credit_ok` out 1: credit count is non-zero, so upstream may issue.
- `s_axis_tdata` in W: quotient from the divider.
- `s_axis_tflag` in 3: divider flag. Bit 0 = zero, bit 1 = Inf, bit 2 = NaN.
- `s_axis_tvalid` in 1: result valid. There is no ready; the word is always taken.
- `m_axis_tdata` out W: buffered quotient.
- `m_axis_tuser` out 3: buffered flag.
- `m_axis_tvalid` out 1: FIFO is not empty.
- `m_axis_tready` in 1: downstream accepts.
- `fill` out AW+1: current FIFO occupancy.
- `overflow` out 1: sticky. A result arrived while the FIFO was full with no pop.
- `issue_err` out 1: sticky. `s_issue` was asserted with zero credits.
- `clr_stats` in 1: synchronous clear of the statistics counters and both sticky bits.
- `cnt_zero`, `cnt_inf`, `cnt_nan` out 16 each: saturating per-flag counters.

## Operation
- Push: `s_axis_tvalid` = 1 writes `{tflag, tdata}` at the write pointer.
  - Accepted when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - Otherwise the word is dropped, `overflow` is set, and the pointers are unchanged.
- Pop: `m_axis_tvalid` && `m_axis_tready`. The read pointer advances.
- FIFO behaviour:
  - First-word fall-through: `m_axis_tdata` and `m_axis_tuser` are a combinational read at the read pointer.
  - Data and user must hold stable while `tvalid` is high and `tready` is low.
- Pointers are AW bits wide and wrap at DEPTH.
- `fill` update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Credits, a register of AW+1 bits. Credits = DEPTH − (results in flight + stored):
  - Starts at DEPTH.
  - Decrements on `s_issue`.
  - Increments on pop.
  - Issue and pop in the same cycle leaves it unchanged.
  - `s_issue` at 0 credits sets `issue_err`, leaves the count at 0, and still counts a pop if one occurs.
  - The count never exceeds DEPTH.
- `s_credit_ok` = (credits != 0).
- Statistics: on each accepted push, increment the counter for every set flag bit, saturating at 0xFFFF. Dropped words are not counted.
- `clr_stats` takes priority over an increment in the same cycle.

## Timing
- Reset values:
  - Pointers, `fill`, sticky bits and statistics counters are 0.
  - Credits = DEPTH, so `s_credit_ok` = 1.
  - `m_axis_tvalid` = 0.
  - `m_axis_tdata` and `m_axis_tuser` are don't-care while `m_axis_tvalid` = 0.
- Latency: a push in cycle N makes the word visible on `m_axis` in cycle N+1. There is no same-cycle bypass when the FIFO is empty.
- `s_credit_ok` reflects the registered credit count, with 1-cycle update latency.
  - Upstream is allowed one issue per cycle while it is high.
- A reset asserted mid-operation discards all stored and in-flight state immediately. This is asynchronous.

## Structure
- Shared package holds:
  - Flag bit indices `FLAG_ZERO` = 0, `FLAG_INF` = 1, `FLAG_NAN` = 2.
  - The word-width function W(EXP, FRA), shared with `tdiv`.
- Sub-module `sync_fifo_fwft`: storage, pointers, `fill`, full and empty.
- The top level holds the credit logic, sticky bits and statistics.

## Test plan
- Basic order: issue and push 0x3C00, 0x4000, 0x7C00 (flag 010) with `tready` = 1.
  - Outputs appear in order, one cycle after each push.
  - `cnt_inf` = 1.
- Fill and drain (DEPTH = 8): issue 8, push 8 with `tready` = 0.
  - `fill` = 8, `s_credit_ok` = 0.
  - Set `tready` = 1: 8 words drain in order and credits return to 8.
- Overflow: 8 stored, push a 9th with `tready` = 0.
  - `overflow` = 1, `fill` stays 8, the 9th word never appears.
  - Repeat the 9th push with `tready` = 1: it is accepted and `fill` stays 8.
- Credit error: at 0 credits assert `s_issue`.
  - `issue_err` = 1, credits stay 0.
  - Same-cycle issue plus pop keeps the count unchanged.
- Saturation and clear: preload `cnt_nan` to 0xFFFE, then push NaN (flag 100) three times.
  - `cnt_nan` = 0xFFFF.
  - `clr_stats` coincident with a NaN push gives 0.
- Reset mid-stream: with 5 words stored, assert `aresetn`.
  - `m_axis_tvalid` drops at once, `fill` = 0, credits = 8.
